// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency req/ack memory port between instruction fetch (I) and data (D).
// D has fixed priority; a starvation counter forces an I win after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_type,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [2:0]    m_type,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          if_stall,
  output logic          mem_stall,
  output logic          err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE_I = 2'd1;
  localparam logic [1:0] ISSUE_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [2:0]    m_type_q, m_type_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          err_q, err_d;
  logic          i_forced;

  assign i_forced = i_req && (starve_cnt_q == STARVE_LIM);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_type_d     = m_type_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d   = ISSUE_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_type_d  = d_type;
          tmo_cnt_d = '0;
          if (i_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
        end else if (i_req) begin
          state_d      = ISSUE_I;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
          m_type_d     = 3'b000;
          tmo_cnt_d    = '0;
          starve_cnt_d = '0;
        end
      end

      ISSUE_I, ISSUE_D: begin
        // Completion and timeout both leave through RESP so the ready pulse comes one cycle later.
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = RESP;
          if (state_q == ISSUE_I) begin
            i_rdata_d = m_rdata;
            i_ready_d = 1'b1;
          end else begin
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
            d_ready_d = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          m_req_d = 1'b0;
          state_d = RESP;
          err_d   = 1'b1;
          if (state_q == ISSUE_I) begin
            i_rdata_d = '0;
            i_ready_d = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_ready_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_type_q     <= 3'b000;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_type_q     <= m_type_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      err_q        <= err_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_type    = m_type_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign err       = err_q;
  assign if_stall  = i_req & ~i_ready_q;
  assign mem_stall = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requesters push expected responses into per-port
// queues, a monitor pops them on every ready pulse, and a small memory model answers m_req.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [2:0]    d_type = 3'b000;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [2:0]    m_type;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ack = 1'b0;
  logic          if_stall;
  logic          mem_stall;
  logic          err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_i[$];
  exp_t exp_d[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_i_cyc = 0;
  int last_d_cyc = 0;

  logic [31:0] mem_img [logic [31:0]];
  int          ws = 0;
  bit          ack_hold = 1'b0;
  int          wcnt = 0;
  logic        ack_we = 1'b0;
  logic [2:0]  ack_type = 3'b000;
  logic [31:0] ack_addr = '0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .if_stall(if_stall), .mem_stall(mem_stall), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory answers after ws wait cycles; stores return junk on m_rdata so a kept d_rdata is visible.
  always @(negedge clk) begin
    m_ack = 1'b0;
    if (rst && m_req && !ack_hold) begin
      if (wcnt == ws) begin
        m_ack    = 1'b1;
        m_rdata  = m_we ? 32'hDEADBEEF :
                   (mem_img.exists(m_addr) ? mem_img[m_addr] : 32'hBAD00000);
        ack_we   = m_we;
        ack_type = m_type;
        ack_addr = m_addr;
        if (m_we) mem_img[m_addr] = m_wdata;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (i_ready) begin
      last_i_cyc = cyc;
      if (exp_i.size() == 0) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL unexpected_i_ready: got i_ready=1, expected no pulse");
      end else begin
        e = exp_i.pop_front();
        check_output("i_rdata", i_rdata, e.rdata);
        check_output("i_err", 32'(err), 32'(e.err));
      end
    end
    if (d_ready) begin
      last_d_cyc = cyc;
      if (exp_d.size() == 0) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL unexpected_d_ready: got d_ready=1, expected no pulse");
      end else begin
        e = exp_d.pop_front();
        check_output("d_rdata", d_rdata, e.rdata);
        check_output("d_err", 32'(err), 32'(e.err));
      end
    end
    if (err && !i_ready && !d_ready) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL err_without_ready: got err=1, expected 0");
    end
  end

  task automatic push_i(input logic [31:0] rd, input logic e);
    exp_t t;
    t.rdata = rd; t.err = e;
    exp_i.push_back(t);
  endtask

  task automatic push_d(input logic [31:0] rd, input logic e);
    exp_t t;
    t.rdata = rd; t.err = e;
    exp_d.push_back(t);
  endtask

  task automatic wait_pulse(input bit is_d, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = is_d ? d_ready : i_ready;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL %s_timeout: no ready after %0d cycles, expected a pulse", name, n);
    end
  endtask

  task automatic i_txn(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    push_i(exp_rd, exp_err);
    i_req = 1'b1; i_addr = addr;
    wait_pulse(1'b0, "i_txn");
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] typ, input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    push_d(exp_rd, exp_err);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_type = typ;
    wait_pulse(1'b1, "d_txn");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // D held high back to back for five loads while one fetch waits; the fetch must win fifth.
  task automatic starvation_round(input string tag);
    int dseen = 0;
    fork
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) push_d(32'h5555AAAA, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_type = 3'b010;
        for (int k = 0; k < 5; k++) wait_pulse(1'b1, "starve_d");
        @(posedge clk); #1;
        d_req = 1'b0;
      end
      begin
        int n = 0;
        @(posedge clk); #1;
        push_i(32'h66666666, 1'b0);
        i_req = 1'b1; i_addr = 32'h600;
        do begin
          @(negedge clk);
          n++;
          if (d_ready) dseen++;
        end while (!i_ready && n < 400);
        if (!i_ready) begin
          n_cmp++; n_fail++;
          $display("[TB] FAIL %s_i_timeout: no i_ready, expected a pulse", tag);
        end
        check_output({tag, "_d_wins_before_i"}, 32'(dseen), 32'd4);
        @(posedge clk); #1;
        i_req = 1'b0;
      end
    join
  endtask

  task automatic apply_stimulus();
    int c0;
    int hi;
    int n;

    mem_img[32'h100] = 32'h00500093;
    mem_img[32'h300] = 32'h13000013;
    mem_img[32'h40]  = 32'h12345678;
    mem_img[32'h500] = 32'h5555AAAA;
    mem_img[32'h600] = 32'h66666666;

    // Reset values
    #2 rst = 1'b0;
    @(negedge clk);
    check_output("rst_m_req", 32'(m_req), 32'd0);
    check_output("rst_m_addr", m_addr, 32'h0);
    check_output("rst_i_ready", 32'(i_ready), 32'd0);
    check_output("rst_d_ready", 32'(d_ready), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: lone fetch, zero-wait memory
    @(posedge clk); #1;
    c0 = cyc;
    push_i(32'h00500093, 1'b0);
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check_output("t1_if_stall_N", 32'(if_stall), 32'd1);
    @(negedge clk);
    check_output("t1_m_req", 32'(m_req), 32'd1);
    check_output("t1_m_addr", m_addr, 32'h100);
    check_output("t1_m_we", 32'(m_we), 32'd0);
    check_output("t1_if_stall_N1", 32'(if_stall), 32'd1);
    wait_pulse(1'b0, "t1");
    check_output("t1_latency", cyc - c0, 32'd2);
    check_output("t1_if_stall_ready", 32'(if_stall), 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0;

    // Test 2: simultaneous requests, D store wins
    fork
      d_txn(1'b1, 32'h2000, 32'hCAFEF00D, 3'b000, 32'h0, 1'b0);
      i_txn(32'h300, 32'h13000013, 1'b0);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("t2_m_we", 32'(m_we), 32'd1);
        check_output("t2_m_addr", m_addr, 32'h2000);
        check_output("t2_m_wdata", m_wdata, 32'hCAFEF00D);
        check_output("t2_if_stall", 32'(if_stall), 32'd1);
      end
    join
    check_output("t2_d_to_i_spacing", last_i_cyc - last_d_cyc, 32'd3);
    check_output("t2_i_m_we", 32'(ack_we), 32'd0);
    check_output("t2_store_written", mem_img[32'h2000], 32'hCAFEF00D);

    // Test 3: starvation; second round proves the counter restarted from zero
    starvation_round("t3a");
    starvation_round("t3b");

    // Test 4: memory never acks, abort after TIMEOUT cycles
    ack_hold = 1'b1;
    @(posedge clk); #1;
    push_d(32'h0, 1'b1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_type = 3'b010;
    hi = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_req) hi++;
    end while (!d_ready && n < 200);
    if (!d_ready) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL t4_timeout: no d_ready after %0d cycles, expected abort pulse", n);
    end
    check_output("t4_m_req_cycles", 32'(hi), 32'(TIMEOUT));
    check_output("t4_m_req_dropped", 32'(m_req), 32'd0);
    @(posedge clk); #1;
    d_req = 1'b0;
    ack_hold = 1'b0;
    i_txn(32'h100, 32'h00500093, 1'b0);

    // Test 5: wait-stated load, then a store that must not disturb d_rdata
    ws = 3;
    d_txn(1'b0, 32'h40, 32'h0, 3'b101, 32'h12345678, 1'b0);
    check_output("t5_m_type", 32'(ack_type), 32'd5);
    check_output("t5_m_addr", ack_addr, 32'h40);
    d_txn(1'b1, 32'h44, 32'hFFFF0000, 3'b010, 32'h12345678, 1'b0);
    check_output("t5_d_rdata_kept", d_rdata, 32'h12345678);
    i_txn(32'h44, 32'hFFFF0000, 1'b0);
    check_output("t5_i_type_forced", 32'(ack_type), 32'd0);
    ws = 0;

    // Test 6: reset while the D access is in flight
    ack_hold = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_type = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check_output("t6_m_req_before", 32'(m_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("t6_m_req_async", 32'(m_req), 32'd0);
    check_output("t6_d_ready", 32'(d_ready), 32'd0);
    repeat (2) @(negedge clk);
    ack_hold = 1'b0;
    push_d(32'h12345678, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_output("t6_regrant", 32'(m_req), 32'd1);
    wait_pulse(1'b1, "t6");
    @(posedge clk); #1;
    d_req = 1'b0;

    repeat (5) @(negedge clk);
    check_output("left_exp_i", 32'(exp_i.size()), 32'd0);
    check_output("left_exp_d", 32'(exp_d.size()), 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
